// File: rtl/audio_fifo_pkg.sv
// Shared definitions for the audio sample FIFO.
// Holds the ceiling-log2 helper, the channel-tag width derivation and the
// default almost-full / almost-empty thresholds used by audio_sync_fifo.
package audio_fifo_pkg;

    // Default almost-empty threshold in words.
    localparam int DEF_ALMOST_EMPTY_NUM = 4;

    // Ceiling log2 of a positive integer; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Channel tag width: one bit minimum so a mono stream still has a tag field.
    function automatic int ch_width(input int channels);
        return (channels <= 1) ? 1 : clog2(channels);
    endfunction

    // Default almost-full threshold: four words short of full.
    function automatic int def_almost_full(input int depth_width);
        return (32'sd1 <<< depth_width) - 4;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM for the FIFO storage array.
// One write port, one registered synchronous read port; the array itself has
// no reset, so it maps onto block RAM.
// Ports:
//   i_clk      clock
//   i_wr_en    write strobe, i_wr_addr / i_wr_data written at the edge
//   i_rd_en    read strobe, o_rd_data loads mem[i_rd_addr] at the edge
//   o_rd_data  registered read data, held while i_rd_en is low
module fifo_sdp_ram #(
    parameter int WIDTH      = 17,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    logic [WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
    logic [WIDTH-1:0] r_rd_data;

    // Storage write and registered read; read-during-write returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/audio_sync_fifo.sv
// Single-clock audio sample FIFO with channel tagging, optional
// first-word-fall-through, synchronous flush and sticky error flags.
// Ports:
//   clk, rst, flush                   clock, sync active-high reset, sync clear
//   wr_en, wr_data, wr_full,
//   almost_full, wr_ch                write side; wr_ch is the tag of the next write
//   rd_en, rd_data, rd_ch, rd_valid,
//   rd_empty, almost_empty            read side (rd_en acknowledges in FWFT mode)
//   level                             stored word count, 0..2^DEPTH_WIDTH
//   overflow, underflow               sticky rejected-request flags
module audio_sync_fifo
    import audio_fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 16,
    parameter int DEPTH_WIDTH      = 11,
    parameter int CHANNELS         = 2,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = def_almost_full(DEPTH_WIDTH),
    parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM,
    localparam int CH_WIDTH        = ch_width(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic [CH_WIDTH-1:0]   wr_ch,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CH_WIDTH-1:0]   rd_ch,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [DEPTH_WIDTH:0]  level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int LVL_W  = DEPTH_WIDTH + 1;
    localparam int WORD_W = DATA_WIDTH + CH_WIDTH;
    localparam int DEPTH  = 1 << DEPTH_WIDTH;

    logic [DEPTH_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_full, r_afull, r_aempty, r_empty, r_valid;
    logic                   r_ovf, r_unf;
    logic [CH_WIDTH-1:0]    r_wr_ch;
    logic                   r_q_valid, r_out_valid, r_rd_seen;
    logic [WORD_W-1:0]      r_out_word;

    logic                   w_clear, w_wr_acc, w_rd_acc, w_ram_rd, w_out_load;
    logic                   w_q_valid_nxt, w_out_valid_nxt, w_empty_nxt, w_valid_nxt;
    logic [LVL_W-1:0]       w_level_nxt, w_staged;
    logic [WORD_W-1:0]      w_ram_q;

    fifo_sdp_ram #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .i_clk     (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({r_wr_ch, wr_data}),
        .i_rd_en   (w_ram_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_q)
    );

    // Request acceptance, next level, and the FWFT prefetch pipeline control.
    always_comb begin
        w_clear     = rst || flush;
        w_wr_acc    = wr_en && !r_full && !w_clear;
        w_rd_acc    = rd_en && !r_empty && !w_clear;
        w_level_nxt = r_level + LVL_W'(w_wr_acc) - LVL_W'(w_rd_acc);
        // Words already pulled out of the RAM (read stage + output register).
        w_staged        = LVL_W'(r_q_valid) + LVL_W'(r_out_valid);
        w_out_load      = 1'b0;
        w_ram_rd        = 1'b0;
        w_q_valid_nxt   = 1'b0;
        w_out_valid_nxt = 1'b0;
        if (FWFT != 0) begin
            // Output register refills from the RAM read stage when empty or consumed;
            // the RAM read stage refills whenever it is free or being drained.
            w_out_load      = r_q_valid && (!r_out_valid || w_rd_acc);
            w_ram_rd        = (r_level > w_staged) && (!r_q_valid || w_out_load) && !w_clear;
            w_q_valid_nxt   = w_ram_rd || (r_q_valid && !w_out_load);
            w_out_valid_nxt = w_out_load || (r_out_valid && !w_rd_acc);
            w_empty_nxt     = !w_out_valid_nxt;
            w_valid_nxt     = w_out_valid_nxt;
        end else begin
            w_ram_rd    = w_rd_acc;
            w_empty_nxt = (w_level_nxt == LVL_W'(0));
            w_valid_nxt = w_rd_acc;
        end
    end

    // Pointers, level, flags, channel counter and prefetch state.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_afull     <= (ALMOST_FULL_NUM == 0);
            r_aempty    <= 1'b1;
            r_empty     <= 1'b1;
            r_valid     <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_wr_ch     <= '0;
            r_q_valid   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_rd_seen   <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
                r_wr_ch  <= (r_wr_ch == CH_WIDTH'(CHANNELS - 1)) ? '0 : r_wr_ch + CH_WIDTH'(1);
            end
            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
            end
            if (w_out_load) begin
                r_out_word <= w_ram_q;
            end
            r_level     <= w_level_nxt;
            r_full      <= (w_level_nxt == LVL_W'(DEPTH));
            r_afull     <= (w_level_nxt >= LVL_W'(ALMOST_FULL_NUM));
            r_aempty    <= (w_level_nxt <= LVL_W'(ALMOST_EMPTY_NUM));
            r_empty     <= w_empty_nxt;
            r_valid     <= w_valid_nxt;
            r_q_valid   <= w_q_valid_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_rd_seen   <= r_rd_seen || w_rd_acc;
            // Flags are judged against the pre-edge full/empty state.
            r_ovf       <= r_ovf || (wr_en && r_full);
            r_unf       <= r_unf || (rd_en && r_empty);
        end
    end

    assign wr_full      = r_full;
    assign almost_full  = r_afull;
    assign wr_ch        = r_wr_ch;
    assign rd_valid     = r_valid;
    assign rd_empty     = r_empty;
    assign almost_empty = r_aempty;
    assign level        = r_level;
    assign overflow     = r_ovf;
    assign underflow    = r_unf;
    // Standard mode reads the RAM register directly; it is masked to zero until
    // the first read after reset/flush because the array is not reset.
    assign rd_data = (FWFT != 0) ? r_out_word[DATA_WIDTH-1:0]
                   : (r_rd_seen ? w_ram_q[DATA_WIDTH-1:0] : '0);
    assign rd_ch   = (FWFT != 0) ? r_out_word[WORD_W-1:DATA_WIDTH]
                   : (r_rd_seen ? w_ram_q[WORD_W-1:DATA_WIDTH] : '0);

endmodule

// File: tb/tb_audio_sync_fifo.sv
module tb_audio_sync_fifo;

    logic clk = 1'b0;
    logic rst;

    logic        s_flush, s_wr_en, s_rd_en;
    logic [15:0] s_wr_data, s_rd_data;
    logic        s_wr_full, s_af, s_rd_valid, s_rd_empty, s_ae, s_ovf, s_unf;
    logic [0:0]  s_wr_ch, s_rd_ch;
    logic [4:0]  s_level;

    logic        f_flush, f_wr_en, f_rd_en;
    logic [15:0] f_wr_data, f_rd_data;
    logic        f_wr_full, f_af, f_rd_valid, f_rd_empty, f_ae, f_ovf, f_unf;
    logic [0:0]  f_wr_ch, f_rd_ch;
    logic [4:0]  f_level;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] sb_q[$];
    logic [16:0] f_q[$];
    logic [16:0] sb_word;
    int          m_level;
    logic        m_wr_ch, m_ovf, m_unf;

    always #5 clk = ~clk;

    audio_sync_fifo #(
        .DATA_WIDTH(16), .DEPTH_WIDTH(4), .CHANNELS(2), .FWFT(0),
        .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)
    ) dut_std (
        .clk(clk), .rst(rst), .flush(s_flush), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .wr_full(s_wr_full), .almost_full(s_af), .wr_ch(s_wr_ch), .rd_en(s_rd_en),
        .rd_data(s_rd_data), .rd_ch(s_rd_ch), .rd_valid(s_rd_valid), .rd_empty(s_rd_empty),
        .almost_empty(s_ae), .level(s_level), .overflow(s_ovf), .underflow(s_unf)
    );

    audio_sync_fifo #(
        .DATA_WIDTH(16), .DEPTH_WIDTH(4), .CHANNELS(2), .FWFT(1),
        .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)
    ) dut_fwft (
        .clk(clk), .rst(rst), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
        .wr_full(f_wr_full), .almost_full(f_af), .wr_ch(f_wr_ch), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_ch(f_rd_ch), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
        .almost_empty(f_ae), .level(f_level), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0;
        m_wr_ch = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        sb_q.delete();
    endtask

    task automatic s_check_state();
        check_value("s_level",        32'(s_level),    32'(m_level));
        check_value("s_wr_full",      32'(s_wr_full),  32'(m_level == 16));
        check_value("s_almost_full",  32'(s_af),       32'(m_level >= 12));
        check_value("s_rd_empty",     32'(s_rd_empty), 32'(m_level == 0));
        check_value("s_almost_empty", 32'(s_ae),       32'(m_level <= 2));
        check_value("s_overflow",     32'(s_ovf),      32'(m_ovf));
        check_value("s_underflow",    32'(s_unf),      32'(m_unf));
        check_value("s_wr_ch",        32'(s_wr_ch),    32'(m_wr_ch));
    endtask

    // One standard-mode cycle: model predicts acceptance, scoreboard tracks data.
    task automatic s_cycle(input logic we, input logic [15:0] wd, input logic re);
        logic wacc, racc;
        wacc = we && (m_level != 16);
        racc = re && (m_level != 0);
        if (wacc) begin
            sb_q.push_back({m_wr_ch, wd});
            m_wr_ch = ~m_wr_ch;
        end
        if (we && !wacc) m_ovf = 1'b1;
        if (re && !racc) m_unf = 1'b1;
        m_level = m_level + int'(wacc) - int'(racc);
        s_wr_en = we; s_wr_data = wd; s_rd_en = re;
        @(posedge clk); #1;
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        check_value("s_rd_valid", 32'(s_rd_valid), 32'(racc));
        if (s_rd_valid === 1'b1 && sb_q.size() != 0) begin
            sb_word = sb_q.pop_front();
            check_value("s_rd_data", 32'(s_rd_data), 32'(sb_word[15:0]));
            check_value("s_rd_ch",   32'(s_rd_ch),   32'(sb_word[16]));
        end
        s_check_state();
    endtask

    task automatic f_check_reset();
        check_value("f_rst_level",    32'(f_level),    32'd0);
        check_value("f_rst_full",     32'(f_wr_full),  32'd0);
        check_value("f_rst_af",       32'(f_af),       32'd0);
        check_value("f_rst_ae",       32'(f_ae),       32'd1);
        check_value("f_rst_empty",    32'(f_rd_empty), 32'd1);
        check_value("f_rst_valid",    32'(f_rd_valid), 32'd0);
        check_value("f_rst_data",     32'(f_rd_data),  32'd0);
        check_value("f_rst_rd_ch",    32'(f_rd_ch),    32'd0);
        check_value("f_rst_wr_ch",    32'(f_wr_ch),    32'd0);
        check_value("f_rst_ovf",      32'(f_ovf),      32'd0);
        check_value("f_rst_unf",      32'(f_unf),      32'd0);
    endtask

    // Standard-mode clear via rst or flush, with both requests asserted alongside.
    task automatic s_clear(input logic use_rst);
        rst = use_rst; s_flush = ~use_rst;
        s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 16'hFFFF;
        @(posedge clk); #1;
        rst = 1'b0; s_flush = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0;
        model_reset();
        s_check_state();
        check_value("s_clr_valid", 32'(s_rd_valid), 32'd0);
        check_value("s_clr_data",  32'(s_rd_data),  32'd0);
        check_value("s_clr_rd_ch", 32'(s_rd_ch),    32'd0);
    endtask

    task automatic f_step(input logic we, input logic [15:0] wd, input logic re);
        f_wr_en = we; f_wr_data = wd; f_rd_en = re;
        @(posedge clk); #1;
        f_wr_en = 1'b0; f_rd_en = 1'b0;
    endtask

    task automatic f_clear();
        f_flush = 1'b1; f_wr_en = 1'b1; f_rd_en = 1'b1; f_wr_data = 16'hFFFF;
        @(posedge clk); #1;
        f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0;
        f_q.delete();
        f_check_reset();
    endtask

    initial begin
        rst = 1'b1;
        s_flush = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = 16'h0;
        f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 16'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        s_check_state();
        check_value("s_init_data", 32'(s_rd_data), 32'd0);
        f_check_reset();

        // Standard mode: fill then drain.
        for (int i = 0; i < 16; i++) s_cycle(1'b1, 16'(i), 1'b0);
        for (int i = 0; i < 16; i++) s_cycle(1'b0, 16'h0, 1'b1);

        // Overflow: 17 writes, the last dropped; drain 16.
        for (int i = 0; i < 17; i++) s_cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 16; i++) s_cycle(1'b0, 16'h0, 1'b1);

        // Underflow and simultaneous requests at empty and full.
        s_clear(1'b0);
        s_cycle(1'b0, 16'h0, 1'b1);
        s_cycle(1'b1, 16'h0055, 1'b1);
        for (int i = 0; i < 15; i++) s_cycle(1'b1, 16'h0060 + 16'(i), 1'b0);
        s_cycle(1'b1, 16'h0077, 1'b1);
        for (int i = 0; i < 15; i++) s_cycle(1'b0, 16'h0, 1'b1);

        // Flush mid-stream with requests asserted, then restart at channel 0.
        s_clear(1'b0);
        for (int i = 0; i < 9; i++) s_cycle(1'b1, 16'h0200 + 16'(i), 1'b0);
        s_clear(1'b0);
        s_cycle(1'b1, 16'h0300, 1'b0);
        s_cycle(1'b1, 16'h0301, 1'b0);
        s_cycle(1'b0, 16'h0, 1'b1);
        s_cycle(1'b0, 16'h0, 1'b1);

        // Reset mid-operation: 5 words stored and overflow set.
        for (int i = 0; i < 17; i++) s_cycle(1'b1, 16'h0400 + 16'(i), 1'b0);
        for (int i = 0; i < 11; i++) s_cycle(1'b0, 16'h0, 1'b1);
        s_clear(1'b1);
        f_check_reset();

        // FWFT: two-cycle fall-through of a single word.
        f_step(1'b1, 16'hA5A5, 1'b0);
        check_value("f_lat_level_n",  32'(f_level),    32'd1);
        check_value("f_lat_valid_n",  32'(f_rd_valid), 32'd0);
        check_value("f_lat_empty_n",  32'(f_rd_empty), 32'd1);
        f_step(1'b0, 16'h0, 1'b0);
        check_value("f_lat_valid_n1", 32'(f_rd_valid), 32'd0);
        f_step(1'b0, 16'h0, 1'b0);
        check_value("f_lat_valid_n2", 32'(f_rd_valid), 32'd1);
        check_value("f_lat_empty_n2", 32'(f_rd_empty), 32'd0);
        check_value("f_lat_data_n2",  32'(f_rd_data),  32'hA5A5);
        check_value("f_lat_ch_n2",    32'(f_rd_ch),    32'd0);
        f_step(1'b0, 16'h0, 1'b1);
        check_value("f_lat_valid_n3", 32'(f_rd_valid), 32'd0);
        check_value("f_lat_level_n3", 32'(f_level),    32'd0);
        check_value("f_lat_empty_n3", 32'(f_rd_empty), 32'd1);
        check_value("f_lat_unf_n3",   32'(f_unf),      32'd0);

        // FWFT underflow and simultaneous requests while empty.
        f_step(1'b0, 16'h0, 1'b1);
        check_value("f_unf_flag",  32'(f_unf),      32'd1);
        check_value("f_unf_valid", 32'(f_rd_valid), 32'd0);
        f_step(1'b1, 16'h1234, 1'b1);
        check_value("f_simul_level", 32'(f_level), 32'd1);
        f_clear();

        // FWFT fill to full, overflow, then stream out one word per cycle.
        for (int i = 0; i < 16; i++) begin
            f_q.push_back({1'(i % 2), 16'h0500 + 16'(i)});
            f_step(1'b1, 16'h0500 + 16'(i), 1'b0);
            check_value("f_fill_level", 32'(f_level),   32'(i + 1));
            check_value("f_fill_full",  32'(f_wr_full), 32'(i == 15));
            check_value("f_fill_af",    32'(f_af),      32'(i + 1 >= 12));
        end
        f_step(1'b1, 16'h05FF, 1'b0);
        check_value("f_ovf_flag",  32'(f_ovf),   32'd1);
        check_value("f_ovf_level", 32'(f_level), 32'd16);
        check_value("f_ovf_wr_ch", 32'(f_wr_ch), 32'd0);
        for (int k = 0; k < 16; k++) begin
            check_value("f_stream_valid", 32'(f_rd_valid), 32'd1);
            if (f_q.size() != 0) begin
                sb_word = f_q.pop_front();
                check_value("f_stream_data", 32'(f_rd_data), 32'(sb_word[15:0]));
                check_value("f_stream_ch",   32'(f_rd_ch),   32'(sb_word[16]));
            end
            f_step(1'b0, 16'h0, 1'b1);
            check_value("f_stream_level", 32'(f_level), 32'(15 - k));
        end
        check_value("f_drain_valid", 32'(f_rd_valid), 32'd0);
        check_value("f_drain_empty", 32'(f_rd_empty), 32'd1);

        // FWFT flush mid-stream, then fresh data starts at channel 0.
        f_clear();
        for (int i = 0; i < 9; i++) f_step(1'b1, 16'h0600 + 16'(i), 1'b0);
        check_value("f_pre_flush_level", 32'(f_level), 32'd9);
        f_clear();
        f_step(1'b1, 16'h0BEE, 1'b0);
        f_step(1'b0, 16'h0, 1'b0);
        f_step(1'b0, 16'h0, 1'b0);
        check_value("f_post_flush_valid", 32'(f_rd_valid), 32'd1);
        check_value("f_post_flush_data",  32'(f_rd_data),  32'h0BEE);
        check_value("f_post_flush_ch",    32'(f_rd_ch),    32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
